// File: rtl/spectrum_bar_display_if.sv
// Pixel-side bus of the spectrum bar renderer: bin magnitudes and raw VGA timing
// in, registered colour and delayed syncs out.
interface spectrum_bar_display_if #(
    parameter int BINS   = 16,
    parameter int DATA_W = 16,
    parameter int X_W    = 10,
    parameter int Y_W    = 10
);
    logic [BINS*DATA_W-1:0] freqs;
    logic [X_W-1:0]         x_px;
    logic [Y_W-1:0]         y_px;
    logic                   activevideo;
    logic                   hsync_in;
    logic                   vsync_in;
    logic                   peak_show;
    logic                   r, g, b;
    logic                   hsync, vsync;

    modport master (
        output freqs, x_px, y_px, activevideo, hsync_in, vsync_in, peak_show,
        input  r, g, b, hsync, vsync
    );

    modport slave (
        input  freqs, x_px, y_px, activevideo, hsync_in, vsync_in, peak_show,
        output r, g, b, hsync, vsync
    );
endinterface

// File: rtl/spectrum_bar_display.sv
// Horizontal bar renderer for sDFT bins: per-frame bin snapshot, optional decaying
// peak markers, two-stage pixel pipeline with syncs delayed to match.
module spectrum_bar_display #(
    parameter int BINS         = 16,
    parameter int DATA_W       = 16,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int BAR_PITCH    = 10,
    parameter int BAR_H        = 9,
    parameter int SHIFT        = 0,
    parameter int X_MAX        = 639,
    parameter int DECAY_FRAMES = 4,
    parameter int PEAK_EN      = 1
) (
    input logic                   clk,
    input logic                   reset,
    spectrum_bar_display_if.slave bus
);
    localparam int SLOT_W = $clog2(BINS + 1);
    localparam int IDX_W  = (BINS > 1) ? $clog2(BINS) : 1;
    localparam int ROW_W  = (BAR_PITCH > 1) ? $clog2(BAR_PITCH) : 1;
    localparam int CW     = (DATA_W > X_W) ? DATA_W : X_W;
    localparam int DC_W   = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    logic [BINS-1:0][X_W-1:0] bar, peak, nb;
    logic                     vs_q, snap_q;

    logic [Y_W-1:0]    y_prev;
    logic [SLOT_W-1:0] slot_q, slot_n;
    logic [ROW_W-1:0]  row_q, row_n;

    logic [SLOT_W-1:0] s1_slot;
    logic [X_W-1:0]    s1_x;
    logic              s1_in_bar, s1_av, s1_hs, s1_vs;

    logic [IDX_W-1:0]  sidx;
    logic [X_W-1:0]    bar_sel, peak_sel;
    logic              lit, below, peak_hit;

    // Snapshot strobe lands one cycle after the vsync rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q   <= 1'b0;
            snap_q <= 1'b0;
        end else begin
            vs_q   <= bus.vsync_in;
            snap_q <= bus.vsync_in & ~vs_q;
        end
    end

    for (genvar i = 0; i < BINS; i++) begin : g_sat
        logic [CW-1:0] mag;
        assign mag   = CW'(bus.freqs[i*DATA_W +: DATA_W]) >> SHIFT;
        assign nb[i] = (mag > CW'(X_MAX)) ? X_W'(X_MAX) : mag[X_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       bar <= '0;
        else if (snap_q) bar <= nb;
    end

    if (PEAK_EN != 0) begin : g_peak
        logic [DC_W-1:0] dcnt;
        logic            dec_now;
        assign dec_now = (dcnt == DC_W'(DECAY_FRAMES - 1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dcnt <= '0;
                peak <= '0;
            end else if (snap_q) begin
                dcnt <= dec_now ? '0 : dcnt + 1'b1;
                for (int i = 0; i < BINS; i++) begin
                    if (nb[i] >= peak[i])
                        peak[i] <= nb[i];
                    else if (dec_now)
                        peak[i] <= peak[i] - {{(X_W-1){1'b0}}, |peak[i]};
                end
            end
        end

        assign peak_hit = bus.peak_show && (peak_sel != '0) && (s1_x == peak_sel);
    end else begin : g_nopeak
        assign peak     = '0;
        assign peak_hit = 1'b0;
    end

    // Slot/row trackers follow the raster one line at a time instead of dividing y.
    always_comb begin
        slot_n = slot_q;
        row_n  = row_q;
        if (bus.y_px == '0) begin
            slot_n = '0;
            row_n  = '0;
        end else if (bus.y_px != y_prev) begin
            if (row_q == ROW_W'(BAR_PITCH - 1)) begin
                row_n = '0;
                if (slot_q != SLOT_W'(BINS)) slot_n = slot_q + 1'b1;
            end else begin
                row_n = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_prev    <= '0;
            slot_q    <= '0;
            row_q     <= '0;
            s1_slot   <= '0;
            s1_in_bar <= 1'b0;
            s1_x      <= '0;
            s1_av     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
        end else begin
            y_prev    <= bus.y_px;
            slot_q    <= slot_n;
            row_q     <= row_n;
            s1_slot   <= slot_n;
            s1_in_bar <= (slot_n < SLOT_W'(BINS)) && (row_n < ROW_W'(BAR_H));
            s1_x      <= bus.x_px;
            s1_av     <= bus.activevideo;
            s1_hs     <= bus.hsync_in;
            s1_vs     <= bus.vsync_in;
        end
    end

    // Out-of-range slots alias an index here, but in_bar is already low for them.
    assign sidx     = s1_slot[IDX_W-1:0];
    assign bar_sel  = bar[sidx];
    assign peak_sel = peak[sidx];
    assign lit      = s1_av & s1_in_bar;
    assign below    = s1_x < bar_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.r     <= 1'b0;
            bus.g     <= 1'b0;
            bus.b     <= 1'b0;
            bus.hsync <= 1'b0;
            bus.vsync <= 1'b0;
        end else begin
            bus.r     <= lit & (below | peak_hit);
            bus.g     <= lit & below;
            bus.b     <= lit & below;
            bus.hsync <= s1_hs;
            bus.vsync <= s1_vs;
        end
    end
endmodule

// File: tb/tb_spectrum_bar_display.sv
// Directed bench for spectrum_bar_display: snapshot timing, bar/gap geometry,
// saturation, peak hold and decay, latency and mid-frame reset.
module tb_spectrum_bar_display;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spectrum_bar_display_if #(.BINS(16), .DATA_W(16), .X_W(10), .Y_W(10)) bus ();

    spectrum_bar_display #(
        .BINS(16), .DATA_W(16), .X_W(10), .Y_W(10), .BAR_PITCH(10), .BAR_H(9),
        .SHIFT(0), .X_MAX(639), .DECAY_FRAMES(4), .PEAK_EN(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk) bus.vsync_in = 1'b1;
        @(negedge clk);
        @(negedge clk) bus.vsync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic goto_row(input int y);
        @(negedge clk) bus.y_px = '0;
        for (int i = 1; i <= y; i++) begin
            @(negedge clk) bus.y_px = 10'(i);
        end
    endtask

    task automatic probe(input string tag, input int x, input logic [2:0] exp);
        @(negedge clk) bus.x_px = 10'(x);
        @(negedge clk);
        @(negedge clk);
        chk(tag, {5'b0, bus.r, bus.g, bus.b}, {5'b0, exp});
    endtask

    initial begin
        reset           = 1'b1;
        bus.freqs       = '0;
        bus.x_px        = '0;
        bus.y_px        = '0;
        bus.activevideo = 1'b1;
        bus.hsync_in    = 1'b1;
        bus.vsync_in    = 1'b1;
        bus.peak_show   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb",   {5'b0, bus.r, bus.g, bus.b}, 8'h0);
        chk("rst_hsync", {7'b0, bus.hsync}, 8'h0);
        chk("rst_vsync", {7'b0, bus.vsync}, 8'h0);
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        @(negedge clk) reset = 1'b0;

        // snapshot 1: bin0=100, bin3 saturates to 639, bin5=200
        bus.freqs[0*16 +: 16] = 16'd100;
        bus.freqs[3*16 +: 16] = 16'd5000;
        bus.freqs[5*16 +: 16] = 16'd200;
        snap();

        goto_row(0);
        probe("b0_x0", 0, 3'b111);
        probe("b0_x99", 99, 3'b111);
        probe("b0_x100_noshow", 100, 3'b000);
        bus.peak_show = 1'b1;
        probe("b0_x100_peak", 100, 3'b100);
        bus.peak_show = 1'b0;
        bus.activevideo = 1'b0;
        probe("b0_blank", 50, 3'b000);
        bus.activevideo = 1'b1;

        // latency: pixel and hsync both appear exactly two clocks later
        probe("lat_pre", 150, 3'b000);
        @(negedge clk) begin bus.x_px = 10'd50; bus.hsync_in = 1'b1; end
        @(negedge clk);
        chk("lat1_rgb", {5'b0, bus.r, bus.g, bus.b}, 8'h0);
        chk("lat1_hs", {7'b0, bus.hsync}, 8'h0);
        @(negedge clk);
        chk("lat2_rgb", {5'b0, bus.r, bus.g, bus.b}, 8'h7);
        chk("lat2_hs", {7'b0, bus.hsync}, 8'h1);
        bus.hsync_in = 1'b0;

        goto_row(8);
        probe("b0_row8", 99, 3'b111);
        goto_row(9);
        probe("b0_gap", 50, 3'b000);
        goto_row(10);
        probe("b1_zero", 0, 3'b000);

        bus.peak_show = 1'b1;
        goto_row(30);
        probe("b3_x638", 638, 3'b111);
        probe("b3_x639", 639, 3'b100);
        goto_row(38);
        probe("b3_row38", 638, 3'b111);

        // freqs change without snapshot must not reach the display
        bus.freqs[5*16 +: 16] = 16'd50;
        goto_row(50);
        probe("b5_hold199", 199, 3'b111);
        probe("b5_hold200", 200, 3'b100);

        snap();  // 2
        probe("b5_new49", 49, 3'b111);
        probe("b5_new50", 50, 3'b000);
        probe("b5_pk200", 200, 3'b100);
        snap();  // 3
        probe("b5_pk200_s3", 200, 3'b100);
        snap();  // 4: decay step
        probe("b5_pk199", 199, 3'b100);
        probe("b5_x200", 200, 3'b000);
        repeat (4) snap();  // 5..8
        probe("b5_pk198", 198, 3'b100);
        probe("b5_x199", 199, 3'b000);
        probe("b5_bar49", 49, 3'b111);
        bus.peak_show = 1'b0;
        probe("b5_noshow", 198, 3'b000);
        bus.peak_show = 1'b1;

        goto_row(160);
        probe("out_160", 0, 3'b000);

        // reset mid-frame with bars and peaks live
        goto_row(0);
        bus.hsync_in = 1'b1;
        probe("pre_rst", 50, 3'b111);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("midrst_rgb", {5'b0, bus.r, bus.g, bus.b}, 8'h0);
        chk("midrst_hs", {7'b0, bus.hsync}, 8'h0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        chk("rel1_hs", {7'b0, bus.hsync}, 8'h0);
        @(negedge clk);
        chk("rel2_hs", {7'b0, bus.hsync}, 8'h1);
        bus.hsync_in = 1'b0;

        bus.freqs[0*16 +: 16] = 16'd30;
        snap();
        goto_row(0);
        probe("post_x29", 29, 3'b111);
        probe("post_pk30", 30, 3'b100);
        probe("post_old100", 100, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
